// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared next-PC select codes and default vectors for the
//               MIPS fetch-stage program counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Next-PC source select. NPC_HOLD covers the stall case.
  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_BR   = 3'd1;
  localparam logic [2:0] NPC_RET  = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;
  localparam logic [2:0] NPC_J    = 3'd4;
  localparam logic [2:0] NPC_EXC  = 3'd5;
  localparam logic [2:0] NPC_ERET = 3'd6;
  localparam logic [2:0] NPC_HOLD = 3'd7;

  // Default reset and exception vectors.
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : pc_unit_if
// Description : Redirect requests from decode/execute control into the PC
//               unit, and the fetch PC / EPC / RAS status coming back.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             PCWrite;
  logic             BranchTaken;
  logic [WIDTH-1:0] BranchTarget;
  logic             Jump;
  logic [WIDTH-1:0] JumpTarget;
  logic             Call;
  logic             JumpReg;
  logic             Return;
  logic [WIDTH-1:0] JumpRegTarget;
  logic             Exception;
  logic             ERet;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlus4;
  logic [WIDTH-1:0] EPC;
  logic             RasEmpty;
  logic             RasFull;

  // Control side: issues requests, observes the fetch PC.
  modport master (
    output PCWrite, BranchTaken, BranchTarget, Jump, JumpTarget, Call,
           JumpReg, Return, JumpRegTarget, Exception, ERet,
    input  PCResult, PCPlus4, EPC, RasEmpty, RasFull
  );

  // PC unit side.
  modport slave (
    input  PCWrite, BranchTaken, BranchTarget, Jump, JumpTarget, Call,
           JumpReg, Return, JumpRegTarget, Exception, ERet,
    output PCResult, PCPlus4, EPC, RasEmpty, RasFull
  );
endinterface : pc_unit_if
`default_nettype wire

// File: rtl/pc_unit_return_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_stack
// Description : Circular return-address LIFO. Push when full overwrites the
//               oldest entry; pop when empty does nothing.
// Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_i,
  input  wire logic             pop_i,
  input  wire logic [WIDTH-1:0] data_i,
  output logic      [WIDTH-1:0] top_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign top_o   = mem_q[ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_MAX);

  // Pointer/count next state; the pointer wraps naturally (power-of-two depth).
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (!full_o) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack storage, pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[ptr_d] <= data_i;
    end
  end

endmodule : return_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Fetch-stage program counter with prioritised next-PC select,
//               stall gating, EPC capture and a return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input wire logic   clk,
  input wire logic   rst,
  pc_unit_if.slave   bus
);

  // Targets are word aligned: low two bits are dropped on every load.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty, ras_full;
  logic             ras_push, ras_pop;
  logic [2:0]       npc_sel;

  assign pc_plus4 = pc_q + WIDTH'(4);

  // Arbitrate redirect requests; only the winner may touch the RAS.
  always_comb begin
    npc_sel  = NPC_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (bus.Exception) begin
      npc_sel = NPC_EXC;
    end else if (bus.ERet) begin
      npc_sel = NPC_ERET;
    end else if (!bus.PCWrite) begin
      npc_sel = NPC_HOLD;
    end else if (bus.BranchTaken) begin
      npc_sel = NPC_BR;
    end else if (bus.Return) begin
      if (!ras_empty) begin
        npc_sel = NPC_RET;
        ras_pop = 1'b1;
      end else begin
        npc_sel = NPC_JR;
      end
    end else if (bus.JumpReg) begin
      npc_sel = NPC_JR;
    end else if (bus.Jump) begin
      npc_sel  = NPC_J;
      ras_push = bus.Call;
    end
  end

  // Next-PC mux and EPC capture.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    case (npc_sel)
      NPC_EXC: begin
        pc_d  = EXC_VECTOR & ALIGN_MASK;
        epc_d = pc_q;
      end
      NPC_ERET: pc_d = epc_q & ALIGN_MASK;
      NPC_BR:   pc_d = bus.BranchTarget & ALIGN_MASK;
      NPC_RET:  pc_d = ras_top & ALIGN_MASK;
      NPC_JR:   pc_d = bus.JumpRegTarget & ALIGN_MASK;
      NPC_J:    pc_d = bus.JumpTarget & ALIGN_MASK;
      NPC_SEQ:  pc_d = pc_plus4;
      default:  pc_d = pc_q;
    endcase
  end

  // PC and EPC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR & ALIGN_MASK;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  return_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_plus4),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

  assign bus.PCResult = pc_q;
  assign bus.PCPlus4  = pc_plus4;
  assign bus.EPC      = epc_q;
  assign bus.RasEmpty = ras_empty;
  assign bus.RasFull  = ras_full;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit (32-bit instance
//               plus an 8-bit instance for PC wrap-around).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pc_unit_if #(.WIDTH(32)) bus ();
  pc_unit_if #(.WIDTH(8))  bus8 ();

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0080),
    .RAS_DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_unit #(
    .WIDTH        (8),
    .RESET_VECTOR (8'hFC),
    .EXC_VECTOR   (8'h80),
    .RAS_DEPTH    (4)
  ) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.PCWrite = 1'b1; bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
    bus.Jump = 1'b0; bus.JumpTarget = '0; bus.Call = 1'b0;
    bus.JumpReg = 1'b0; bus.Return = 1'b0; bus.JumpRegTarget = '0;
    bus.Exception = 1'b0; bus.ERet = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    bus8.PCWrite = 1'b0; bus8.BranchTaken = 1'b0; bus8.BranchTarget = '0;
    bus8.Jump = 1'b0; bus8.JumpTarget = '0; bus8.Call = 1'b0;
    bus8.JumpReg = 1'b0; bus8.Return = 1'b0; bus8.JumpRegTarget = '0;
    bus8.Exception = 1'b0; bus8.ERet = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",    bus.PCResult, 32'h0);
    check("rst_pc4",   bus.PCPlus4,  32'h4);
    check("rst_epc",   bus.EPC,      32'h0);
    check("rst_empty", {31'd0, bus.RasEmpty}, 32'd1);
    check("rst_full",  {31'd0, bus.RasFull},  32'd0);
    check("w8_rst_pc",  {24'd0, bus8.PCResult}, 32'hFC);
    check("w8_rst_pc4", {24'd0, bus8.PCPlus4},  32'h00);
    rst = 1'b0;

    // Sequential; 8-bit instance wraps on the same edge
    bus8.PCWrite = 1'b1;
    step();
    check("seq1", bus.PCResult, 32'h4);
    check("w8_wrap_pc",  {24'd0, bus8.PCResult}, 32'h00);
    check("w8_wrap_pc4", {24'd0, bus8.PCPlus4},  32'h04);
    bus8.PCWrite = 1'b0;
    step(); check("seq2", bus.PCResult, 32'h8);
    step(); check("seq3", bus.PCResult, 32'hC);

    // Stall, then stall with a branch request
    bus.PCWrite = 1'b0;
    step(); check("stall1", bus.PCResult, 32'hC);
    step(); check("stall2", bus.PCResult, 32'hC);
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h100;
    step(); check("stall_br", bus.PCResult, 32'hC);
    idle();
    step(); check("seq4", bus.PCResult, 32'h10);

    // Branch outranks Jump+Call; losing call must not push
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h200;
    bus.Jump = 1'b1; bus.Call = 1'b1; bus.JumpTarget = 32'h300;
    step();
    check("prio_pc",    bus.PCResult, 32'h200);
    check("prio_empty", {31'd0, bus.RasEmpty}, 32'd1);
    idle();
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h203;
    step(); check("align", bus.PCResult, 32'h200);

    // Back to 0, then five calls into a 4-deep stack
    bus.BranchTarget = 32'h0;
    step(); check("br_zero", bus.PCResult, 32'h0);
    idle();
    bus.Jump = 1'b1; bus.Call = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.JumpTarget = 32'(i) << 8;
      step();
      check("call_pc", bus.PCResult, 32'(i) << 8);
      if (i == 1) check("call_nonempty", {31'd0, bus.RasEmpty}, 32'd0);
      if (i == 3) check("call_notfull",  {31'd0, bus.RasFull},  32'd0);
      if (i >= 4) check("call_full",     {31'd0, bus.RasFull},  32'd1);
    end
    idle();
    bus.Return = 1'b1; bus.JumpRegTarget = 32'h50;
    step(); check("ret1", bus.PCResult, 32'h404);
    check("ret1_notfull", {31'd0, bus.RasFull}, 32'd0);
    step(); check("ret2", bus.PCResult, 32'h304);
    step(); check("ret3", bus.PCResult, 32'h204);
    step(); check("ret4", bus.PCResult, 32'h104);
    check("ret4_empty", {31'd0, bus.RasEmpty}, 32'd1);
    step(); check("ret_empty_jr", bus.PCResult, 32'h50);
    idle();

    // One call to leave an entry on the stack: pushes 0x54
    bus.Jump = 1'b1; bus.Call = 1'b1; bus.JumpTarget = 32'h24;
    step(); check("call_24", bus.PCResult, 32'h24);
    idle();

    // Exception ignores stall; ERet returns
    bus.PCWrite = 1'b0; bus.Exception = 1'b1;
    step();
    check("exc_pc",    bus.PCResult, 32'h80);
    check("exc_epc",   bus.EPC,      32'h24);
    check("exc_ras",   {31'd0, bus.RasEmpty}, 32'd0);
    bus.Exception = 1'b0; bus.ERet = 1'b1;
    step(); check("eret_pc", bus.PCResult, 32'h24);
    idle();
    bus.Exception = 1'b1;
    step(); check("exc2_pc", bus.PCResult, 32'h80);
    idle();
    step(); check("seq_84", bus.PCResult, 32'h84);
    bus.Exception = 1'b1; bus.ERet = 1'b1;
    step();
    check("exc_eret_pc",  bus.PCResult, 32'h80);
    check("exc_eret_epc", bus.EPC,      32'h84);
    idle();
    bus.ERet = 1'b1;
    step(); check("eret2_pc", bus.PCResult, 32'h84);
    idle();

    // Stack survived the exceptions
    bus.Return = 1'b1; bus.JumpRegTarget = 32'h999;
    step(); check("ret_after_exc", bus.PCResult, 32'h54);
    idle();
    bus.Jump = 1'b1; bus.Call = 1'b1; bus.JumpTarget = 32'h40;
    step();
    check("pc_40",   bus.PCResult, 32'h40);
    check("pre_rst_epc", bus.EPC,  32'h84);
    idle();

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc",    bus.PCResult, 32'h0);
    check("async_rst_epc",   bus.EPC,      32'h0);
    check("async_rst_empty", {31'd0, bus.RasEmpty}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step(); check("post_rst_seq", bus.PCResult, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_unit
`default_nettype wire
